csa_tree_pipelined_accum: RTL
=============================

CSA_TREE_PIPELINED_ACCUM -- requirements
Module: csa_tree_pipelined_accum

Interface
REQ-001 SHALL have parameter BIT_LEN, default 19: width of each input term.
REQ-002 SHALL have parameter NUM_ELEMENTS, default 9: terms per beat, legal range >= 2.
REQ-003 SHALL have parameter LEVELS_PER_STAGE, default 2: CSA levels between pipeline registers, legal range >= 1.
REQ-004 SHALL have parameter ACCUM, default 0: 0 = one result per beat, 1 = multi-beat redundant accumulation.
REQ-005 SHALL have parameter OUT_BIT_LEN, default BIT_LEN + NUM_LEVELS(NUM_ELEMENTS): width of the result pair.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port in_valid, input, 1 bit: a terms beat is offered.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts the beat.
REQ-010 SHALL have port in_first, input, 1 bit: start of accumulation (ACCUM=1 only).
REQ-011 SHALL have port in_last, input, 1 bit: end of accumulation (ACCUM=1 only).
REQ-012 SHALL have port terms, input, BIT_LEN x NUM_ELEMENTS unpacked: unsigned operands.
REQ-013 SHALL have port out_valid, output, 1 bit: the result pair is valid.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-015 SHALL have port out_sum, output, OUT_BIT_LEN bits: redundant sum vector.
REQ-016 SHALL have port out_carry, output, OUT_BIT_LEN bits: redundant carry vector, already weight-aligned.

Function
REQ-017 SHALL reduce terms level by level: groups of three per level pass through 3:2 CSAs, carry shifted left 1, sum zero-extended, leftovers zero-extended and carried forward; every level widens vectors by 1 bit, until two vectors remain.
REQ-018 SHALL compute NUM_LEVELS = 0 when NUM_ELEMENTS = 2, else levels until two vectors remain (NUM_ELEMENTS = 9 -> 4 levels, 5 -> 3 levels).
REQ-019 SHALL register the tree after every LEVELS_PER_STAGE levels, with the final stage always registered; NUM_STAGES = max(1, ceil(NUM_LEVELS/LEVELS_PER_STAGE)).
REQ-020 SHALL satisfy (out_sum + out_carry) mod 2^OUT_BIT_LEN == (sum of accepted terms) mod 2^OUT_BIT_LEN; bits above OUT_BIT_LEN are truncated, narrower vectors zero-extended.
REQ-021 SHALL transfer a beat only on a cycle with in_valid && in_ready, and a result only on a cycle with out_valid && out_ready.
REQ-022 SHALL assert stall = out_valid && !out_ready, freeze every pipeline register and valid bit while stalled, and drive in_ready = !stall.
REQ-023 With ACCUM=0, SHALL raise out_valid exactly NUM_STAGES cycles after acceptance when unstalled, sustaining one result per cycle.
REQ-024 With ACCUM=1, SHALL add each tree-output pair into a registered (acc_s, acc_c) pair via a 4:2 compressor (two chained CSAs); in_first loads the tree pair in place of accumulation.
REQ-025 With ACCUM=1, SHALL raise out_valid with the accumulator pair NUM_STAGES+1 cycles after an accepted in_last beat; non-last beats produce no out_valid.
REQ-026 Beat with in_first && in_last SHALL produce a single-beat result; in_first while an accumulation is open SHALL discard the old accumulation; in_last without a prior in_first SHALL accumulate onto the current accumulator contents.
REQ-027 With ACCUM=0, SHALL ignore in_first and in_last.
REQ-028 out_sum and out_carry SHALL hold stable while out_valid && !out_ready.

Reset
REQ-029 On rst, SHALL clear all stage valids, out_valid, acc_s, acc_c, out_sum, and out_carry to 0 at the next edge, and drive in_ready = 1 from then on.
REQ-030 Data in flight during rst SHALL be dropped; a beat offered in the rst cycle SHALL NOT be accepted.

Structure
REQ-031 Package csa_pkg SHALL hold the NUM_LEVELS and NUM_RESULTS(n) = 2*floor(n/3) + n%3 constant functions, plus NUM_STAGES.
REQ-032 The 3:2 cell SHALL be the existing carry_save_adder sub-module; a per-level combinational generate SHALL be reused with its own width per level.

Verification
REQ-033 BIT_LEN=8, NUM_ELEMENTS=5, LEVELS_PER_STAGE=1, ACCUM=0; all terms 0xFF -> out_valid after 3 cycles, out_sum+out_carry = 0x4FB.
REQ-034 Same configuration, 10 back-to-back random beats with out_ready=1 -> 10 results in order, one per cycle, each matching a reference sum.
REQ-035 out_ready low for 4 cycles while valid -> in_ready low, outputs unchanged, no beat lost or duplicated.
REQ-036 ACCUM=1, OUT_BIT_LEN=11, three beats of 0xFF (first on beat 1, last on beat 3) -> one result, sum mod 2^11 = 0x6F1 (wrap of 0xEF1).
REQ-037 ACCUM=1, two in_first without in_last, then in_first&&in_last with all terms 1 -> result 5.
REQ-038 rst asserted with 2 beats in flight -> next cycle out_valid=0, accumulator 0, no stale result after release.

Source files
------------

// File: rtl/csa_pkg.sv
// csa_pkg: sizing functions shared by the CSA reduction tree and its bench-free users
package csa_pkg;

    function automatic int num_results(input int n);
        return 2 * (n / 3) + n % 3;
    endfunction

    function automatic int level_count(input int n, input int level);
        int m;
        m = n;
        for (int i = 0; i < level; i++) m = num_results(m);
        return m;
    endfunction

    function automatic int num_levels(input int n);
        int m;
        int l;
        m = n;
        l = 0;
        while (m > 2) begin
            m = num_results(m);
            l++;
        end
        return l;
    endfunction

    function automatic int num_stages(input int levels, input int lps);
        return (levels == 0) ? 1 : (levels + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/carry_save_adder.sv
// carry_save_adder: bitwise 3:2 compressor; carry is returned unshifted
module carry_save_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] carry_o
);
    assign sum_o   = a_i ^ b_i ^ c_i;
    assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// File: rtl/csa_tree_pipelined_accum.sv
// csa_tree_pipelined_accum: pipelined 3:2 CSA reduction tree with optional
// redundant multi-beat accumulation and valid/ready flow control.
module csa_tree_pipelined_accum
    import csa_pkg::*;
#(
    parameter int BIT_LEN          = 19,
    parameter int NUM_ELEMENTS     = 9,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int ACCUM            = 0,
    parameter int OUT_BIT_LEN      = BIT_LEN + num_levels(NUM_ELEMENTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [BIT_LEN-1:0]     terms [NUM_ELEMENTS],
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_BIT_LEN-1:0] out_sum,
    output logic [OUT_BIT_LEN-1:0] out_carry
);
    localparam int NL = num_levels(NUM_ELEMENTS);
    localparam int NS = num_stages(NL, LEVELS_PER_STAGE);
    localparam int TW = BIT_LEN + NL;

    logic          stall;
    logic          accept;
    logic [NS-1:0] v_q;
    logic [NS-1:0] f_q;
    logic [NS-1:0] l_q;
    logic [TW-1:0] tree_s_q;
    logic [TW-1:0] tree_c_q;
    logic [TW-1:0] node_in  [NL+1][NUM_ELEMENTS];
    logic [TW-1:0] node_out [NL+1][NUM_ELEMENTS];

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NUM_ELEMENTS; k++) begin : g_in
        assign node_in[0][k] = TW'(terms[k]);
    end

    // Each level works at its own width; vectors live in TW-wide slots, zero above.
    for (genvar l = 0; l < NL; l++) begin : g_level
        localparam int N  = level_count(NUM_ELEMENTS, l);
        localparam int G  = N / 3;
        localparam int R  = num_results(N);
        localparam int IW = BIT_LEN + l;
        for (genvar g = 0; g < G; g++) begin : g_csa
            logic [IW-1:0] s;
            logic [IW-1:0] c;
            carry_save_adder #(.WIDTH(IW)) u_csa (
                .a_i    (node_in[l][3*g][IW-1:0]),
                .b_i    (node_in[l][3*g+1][IW-1:0]),
                .c_i    (node_in[l][3*g+2][IW-1:0]),
                .sum_o  (s),
                .carry_o(c)
            );
            assign node_out[l][2*g]   = TW'(s);
            assign node_out[l][2*g+1] = TW'({c, 1'b0});
        end
        for (genvar k = 2 * G; k < R; k++) begin : g_pass
            assign node_out[l][k] = node_in[l][k+G];
        end
        for (genvar k = R; k < NUM_ELEMENTS; k++) begin : g_zero
            assign node_out[l][k] = '0;
        end
        if ((l + 1) % LEVELS_PER_STAGE == 0 && l + 1 < NL) begin : g_reg
            logic [TW-1:0] r_q [NUM_ELEMENTS];
            always_ff @(posedge clk)
                for (int k = 0; k < NUM_ELEMENTS; k++)
                    if (rst) r_q[k] <= '0;
                    else if (!stall) r_q[k] <= node_out[l][k];
            for (genvar k = 0; k < NUM_ELEMENTS; k++) begin : g_o
                assign node_in[l+1][k] = r_q[k];
            end
        end else begin : g_comb
            for (genvar k = 0; k < NUM_ELEMENTS; k++) begin : g_o
                assign node_in[l+1][k] = node_out[l][k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q      <= '0;
            f_q      <= '0;
            l_q      <= '0;
            tree_s_q <= '0;
            tree_c_q <= '0;
        end else if (!stall) begin
            v_q      <= NS'({v_q, accept});
            f_q      <= NS'({f_q, in_first});
            l_q      <= NS'({l_q, in_last});
            tree_s_q <= node_in[NL][0];
            tree_c_q <= node_in[NL][1];
        end
    end

    if (ACCUM == 0) begin : g_direct
        assign out_valid = v_q[NS-1];
        assign out_sum   = OUT_BIT_LEN'(tree_s_q);
        assign out_carry = OUT_BIT_LEN'(tree_c_q);
    end else begin : g_accum
        logic [OUT_BIT_LEN-1:0] ts, tc, s1, c1, s2, c2;
        logic [OUT_BIT_LEN-1:0] acc_s_d, acc_c_d, acc_s_q, acc_c_q;
        logic                   ov_q;
        assign ts = OUT_BIT_LEN'(tree_s_q);
        assign tc = OUT_BIT_LEN'(tree_c_q);
        // 4:2 compressor: acc pair plus tree pair folded back into a redundant pair
        carry_save_adder #(.WIDTH(OUT_BIT_LEN)) u_c0 (
            .a_i(acc_s_q), .b_i(acc_c_q), .c_i(ts), .sum_o(s1), .carry_o(c1)
        );
        carry_save_adder #(.WIDTH(OUT_BIT_LEN)) u_c1 (
            .a_i(s1), .b_i({c1[OUT_BIT_LEN-2:0], 1'b0}), .c_i(tc), .sum_o(s2), .carry_o(c2)
        );
        assign acc_s_d = f_q[NS-1] ? ts : s2;
        assign acc_c_d = f_q[NS-1] ? tc : {c2[OUT_BIT_LEN-2:0], 1'b0};
        always_ff @(posedge clk) begin
            if (rst) begin
                ov_q    <= 1'b0;
                acc_s_q <= '0;
                acc_c_q <= '0;
            end else if (!stall) begin
                ov_q <= v_q[NS-1] && l_q[NS-1];
                if (v_q[NS-1]) begin
                    acc_s_q <= acc_s_d;
                    acc_c_q <= acc_c_d;
                end
            end
        end
        assign out_valid = ov_q;
        assign out_sum   = acc_s_q;
        assign out_carry = acc_c_q;
    end

endmodule
